// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port arbiter: one display read slot per pixel period,
// remaining cycles round-robined between two writers; RGB/sync outputs aligned.
module fb_port_arbiter #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned BLANK_ONLY  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_tick,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  video_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [1:0]            req,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  output logic [1:0]            gnt,
  output logic                  wr_err,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     vga_rgb,
  output logic                  vga_hsync,
  output logic                  vga_vsync
);

  localparam int unsigned FB_SIZE = FB_W * FB_H;

  logic [1:0]        phase;
  logic              aligned;
  logic              rd_pend;
  logic              ptr;
  logic              disp_slot;
  logic              wr_slot;
  logic              sel;
  logic              grant_any;
  logic              addr_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] disp_addr;

  assign disp_addr = ADDR_W'(32'(y >> SCALE_SHIFT) * FB_W + 32'(x >> SCALE_SHIFT));
  assign sel_addr  = sel ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
  assign sel_data  = sel ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
  assign addr_ok   = 32'(sel_addr) < FB_SIZE;

  // Slot decode and port mux; display read only once phase is aligned to p_tick
  always_comb begin
    disp_slot = 1'b0;
    wr_slot   = 1'b0;
    sel       = ptr;
    grant_any = 1'b0;
    gnt       = 2'b00;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!reset) begin
      disp_slot = aligned && (phase == 2'd1) && video_on;
      wr_slot   = !disp_slot && ((BLANK_ONLY == 0) || !video_on);
    end
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = ptr;
    endcase
    if (disp_slot) begin
      mem_addr = disp_addr;
    end else if (wr_slot && (req != 2'b00)) begin
      grant_any = 1'b1;
      gnt       = 2'b01 << sel;
      mem_addr  = sel_addr;
      mem_wdata = sel_data;
      mem_we    = addr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= 2'd0;
      aligned   <= 1'b0;
      rd_pend   <= 1'b0;
      ptr       <= 1'b0;
      wr_err    <= 1'b0;
      vga_rgb   <= '0;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
    end else begin
      phase  <= p_tick ? 2'd1 : phase + 2'd1;
      wr_err <= grant_any && !addr_ok;
      if (p_tick) aligned <= 1'b1;
      if (grant_any) ptr <= ~sel;
      // Read data returns in phase 2; capture RGB and syncs together
      if (disp_slot) begin
        rd_pend <= 1'b1;
      end else if (aligned && (phase == 2'd2)) begin
        vga_rgb   <= rd_pend ? mem_rdata : '0;
        vga_hsync <= hsync_in;
        vga_vsync <= vsync_in;
        rd_pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter; a second instance covers BLANK_ONLY=1.
module tb_fb_port_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 12;

  logic          clk;
  logic          reset;
  logic          p_tick;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          video_on;
  logic          hsync_in;
  logic          vsync_in;
  logic [1:0]    req;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    gnt,       b_gnt;
  logic          wr_err,    b_wr_err;
  logic [AW-1:0] mem_addr,  b_mem_addr;
  logic          mem_we,    b_mem_we;
  logic [DW-1:0] mem_wdata, b_mem_wdata;
  logic [DW-1:0] vga_rgb,   b_vga_rgb;
  logic          vga_hsync, b_vga_hsync;
  logic          vga_vsync, b_vga_vsync;

  int total = 0;
  int bad   = 0;

  fb_port_arbiter u_dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .req(req), .wr_addr(wr_addr),
    .wr_data(wr_data), .gnt(gnt), .wr_err(wr_err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .vga_rgb(vga_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  fb_port_arbiter #(.BLANK_ONLY(1)) u_blank (
    .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .req(req), .wr_addr(wr_addr),
    .wr_data(wr_data), .gnt(b_gnt), .wr_err(b_wr_err), .mem_addr(b_mem_addr),
    .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
    .vga_rgb(b_vga_rgb), .vga_hsync(b_vga_hsync), .vga_vsync(b_vga_vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From the start of phase 3: run phase 0 with p_tick, land at start of phase 1
  task automatic pixel_end();
    step();
    p_tick = 1'b1;
    step();
    p_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; p_tick = 1'b0; x = '0; y = '0; video_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; req = 2'b11; wr_addr = '0; wr_data = '0;
    mem_rdata = '0;
    step(); step();
    #1;
    total++; if (vga_rgb !== 12'h000) begin bad++; $display("FAIL rst_rgb got=%h exp=000", vga_rgb); end
    total++; if (vga_hsync !== 1'b0) begin bad++; $display("FAIL rst_hsync got=%b exp=0", vga_hsync); end
    total++; if (vga_vsync !== 1'b0) begin bad++; $display("FAIL rst_vsync got=%b exp=0", vga_vsync); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL rst_wr_err got=%b exp=0", wr_err); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", mem_we); end
    reset = 1'b0; req = 2'b00; hsync_in = 1'b0; vsync_in = 1'b0; p_tick = 1'b1;
    step();
    p_tick = 1'b0;
  endtask

  task automatic test_display();
    x = 10'd4; y = 10'd8; video_on = 1'b1; #1;
    total++; if (mem_addr !== 15'd321) begin bad++; $display("FAIL disp_addr got=%0d exp=321", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL disp_we got=%b exp=0", mem_we); end
    step(); mem_rdata = 12'hABC; #1;
    total++; if (vga_rgb !== 12'h000) begin bad++; $display("FAIL disp_rgb_early got=%h exp=000", vga_rgb); end
    step(); mem_rdata = 12'h000; #1;
    total++; if (vga_rgb !== 12'hABC) begin bad++; $display("FAIL disp_rgb_c1 got=%h exp=abc", vga_rgb); end
    step();
    total++; if (vga_rgb !== 12'hABC) begin bad++; $display("FAIL disp_rgb_c2 got=%h exp=abc", vga_rgb); end
    p_tick = 1'b1; step(); p_tick = 1'b0;
    x = 10'd5; video_on = 1'b0; #1;
    total++; if (vga_rgb !== 12'hABC) begin bad++; $display("FAIL disp_rgb_c3 got=%h exp=abc", vga_rgb); end
    total++; if (mem_addr !== 15'd0) begin bad++; $display("FAIL blank_addr got=%0d exp=0", mem_addr); end
    step();
    total++; if (vga_rgb !== 12'hABC) begin bad++; $display("FAIL disp_rgb_c4 got=%h exp=abc", vga_rgb); end
    step();
    total++; if (vga_rgb !== 12'h000) begin bad++; $display("FAIL blank_rgb got=%h exp=000", vga_rgb); end
    pixel_end();
  endtask

  task automatic test_round_robin();
    x = 10'd8; y = 10'd4; video_on = 1'b1; req = 2'b11;
    wr_addr = {15'd200, 15'd100}; wr_data = {12'h222, 12'h111}; #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rr_ph1_gnt got=%b exp=00", gnt); end
    total++; if (mem_addr !== 15'd162) begin bad++; $display("FAIL rr_ph1_addr got=%0d exp=162", mem_addr); end
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rr_ph2_gnt got=%b exp=01", gnt); end
    total++; if (mem_addr !== 15'd100 || mem_we !== 1'b1 || mem_wdata !== 12'h111) begin
      bad++; $display("FAIL rr_ph2_wr got=%0d/%b/%h exp=100/1/111", mem_addr, mem_we, mem_wdata); end
    step();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rr_ph3_gnt got=%b exp=10", gnt); end
    total++; if (mem_addr !== 15'd200 || mem_we !== 1'b1 || mem_wdata !== 12'h222) begin
      bad++; $display("FAIL rr_ph3_wr got=%0d/%b/%h exp=200/1/222", mem_addr, mem_we, mem_wdata); end
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rr_ph0_gnt got=%b exp=01", gnt); end
    p_tick = 1'b1; step(); p_tick = 1'b0; #1;
    total++; if (gnt !== 2'b00 || mem_we !== 1'b0) begin bad++; $display("FAIL rr_disp_gnt got=%b/%b exp=00/0", gnt, mem_we); end
    step();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rr_next_gnt got=%b exp=10", gnt); end
    step(); req = 2'b00; #1;
    total++; if (gnt !== 2'b00 || mem_we !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b/%b exp=00/0", gnt, mem_we); end
    pixel_end();
  endtask

  task automatic test_wr_err();
    video_on = 1'b0; req = 2'b10; wr_addr = {15'd19200, 15'd0}; #1;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL oob_gnt got=%b exp=10", gnt); end
    total++; if (mem_we !== 1'b0 || mem_addr !== 15'd19200) begin
      bad++; $display("FAIL oob_we got=%b/%0d exp=0/19200", mem_we, mem_addr); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL oob_err_early got=%b exp=0", wr_err); end
    step(); req = 2'b01; wr_addr = {15'd19200, 15'd19199}; wr_data = {12'h000, 12'h0F0}; #1;
    total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL oob_err got=%b exp=1", wr_err); end
    total++; if (gnt !== 2'b01 || mem_we !== 1'b1 || mem_addr !== 15'd19199) begin
      bad++; $display("FAIL last_addr got=%b/%b/%0d exp=01/1/19199", gnt, mem_we, mem_addr); end
    step(); req = 2'b00; #1;
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL oob_err_pulse got=%b exp=0", wr_err); end
    pixel_end();
  endtask

  task automatic test_blank_only();
    x = 10'd0; y = 10'd0; video_on = 1'b1; req = 2'b01; wr_addr = {15'd0, 15'd50};
    wr_data = {12'h000, 12'h777}; #1;
    total++; if (b_gnt !== 2'b00) begin bad++; $display("FAIL blk_ph1_gnt got=%b exp=00", b_gnt); end
    step();
    total++; if (b_gnt !== 2'b00 || b_mem_we !== 1'b0) begin bad++; $display("FAIL blk_ph2 got=%b/%b exp=00/0", b_gnt, b_mem_we); end
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL blk_ref_gnt got=%b exp=01", gnt); end
    step();
    total++; if (b_gnt !== 2'b00) begin bad++; $display("FAIL blk_ph3_gnt got=%b exp=00", b_gnt); end
    pixel_end();
    video_on = 1'b0; #1;
    total++; if (b_gnt !== 2'b01 || b_mem_we !== 1'b1 || b_mem_addr !== 15'd50) begin
      bad++; $display("FAIL blk_open got=%b/%b/%0d exp=01/1/50", b_gnt, b_mem_we, b_mem_addr); end
    step(); req = 2'b00;
    step();
    pixel_end();
  endtask

  task automatic test_sync();
    x = 10'd4; y = 10'd8; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; #1;
    total++; if (vga_hsync !== 1'b0) begin bad++; $display("FAIL sync_early_ph1 got=%b exp=0", vga_hsync); end
    step(); mem_rdata = 12'h3C7; #1;
    total++; if (vga_hsync !== 1'b0 || vga_rgb !== 12'h000) begin
      bad++; $display("FAIL sync_early_ph2 got=%b/%h exp=0/000", vga_hsync, vga_rgb); end
    step(); mem_rdata = 12'h000; #1;
    total++; if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || vga_rgb !== 12'h3C7) begin
      bad++; $display("FAIL sync_align got=%b/%b/%h exp=1/1/3c7", vga_hsync, vga_vsync, vga_rgb); end
    pixel_end();
  endtask

  task automatic test_reset_mid();
    x = 10'd4; y = 10'd8; video_on = 1'b1;
    step(); reset = 1'b1; req = 2'b11; mem_rdata = 12'h5A5; #1;
    total++; if (gnt !== 2'b00 || mem_we !== 1'b0) begin bad++; $display("FAIL mid_rst_gnt got=%b/%b exp=00/0", gnt, mem_we); end
    step(); reset = 1'b0; req = 2'b00; #1;
    total++; if (vga_rgb !== 12'h000 || vga_hsync !== 1'b0 || vga_vsync !== 1'b0) begin
      bad++; $display("FAIL mid_rst_out got=%h/%b/%b exp=000/0/0", vga_rgb, vga_hsync, vga_vsync); end
    step(); mem_rdata = 12'h000; #1;
    total++; if (mem_addr !== 15'd0) begin bad++; $display("FAIL mid_unaligned_addr got=%0d exp=0", mem_addr); end
    p_tick = 1'b1; step(); p_tick = 1'b0; #1;
    total++; if (mem_addr !== 15'd321 || mem_we !== 1'b0) begin
      bad++; $display("FAIL mid_resume_addr got=%0d/%b exp=321/0", mem_addr, mem_we); end
    step(); mem_rdata = 12'h5A5;
    step(); mem_rdata = 12'h000; #1;
    total++; if (vga_rgb !== 12'h5A5 || vga_hsync !== 1'b1) begin
      bad++; $display("FAIL mid_resume_rgb got=%h/%b exp=5a5/1", vga_rgb, vga_hsync); end
  endtask

  initial begin
    test_reset();
    test_display();
    test_round_robin();
    test_wr_err();
    test_blank_only();
    test_sync();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between VGA scanout and two pixel writers (game logic, sprite engine).
- Runs on the 100 MHz system clock. Consumes the sync generator's p_tick, x, y, video_on, hsync and vsync.
- Reserves one RAM cycle per pixel period for the display read, round-robins the remaining cycles among the writers, and outputs pipelined RGB and sync, mutually aligned.

Parameters:
FB_W, 160, framebuffer width in stored pixels
FB_H, 120, framebuffer height in stored pixels
SCALE_SHIFT, 2, screen-to-framebuffer downscale as log2 (640x480 -> 160x120)
ADDR_W, 15, RAM address width (must cover FB_W*FB_H)
DATA_W, 12, pixel width, RGB444
BLANK_ONLY, 0, 1 = writers are granted only while video_on=0

Ports:
clk  in  1  system clock, 4x pixel rate
reset  in  1  synchronous, active-high
p_tick  in  1  pixel tick; x/y advance at the clk edge ending this cycle
x  in  10  current horizontal count
y  in  10  current vertical count
video_on  in  1  active display region
hsync_in  in  1  registered hsync from sync generator
vsync_in  in  1  registered vsync from sync generator
req  in  2  write request per writer; held with address/data until granted
wr_addr  in  2*ADDR_W  writer addresses; writer i at [i*ADDR_W +: ADDR_W]
wr_data  in  2*DATA_W  writer pixel data, same packing
gnt  out  2  one-hot, combinational; write executes in the gnt cycle
wr_err  out  1  registered 1-cycle pulse: granted address >= FB_W*FB_H
mem_addr  out  ADDR_W  RAM address, combinational
mem_we  out  1  RAM write enable, combinational
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after address
vga_rgb  out  DATA_W  registered pixel colour
vga_hsync  out  1  hsync_in delayed to align with vga_rgb
vga_vsync  out  1  vsync_in delayed to align with vga_rgb

Behaviour:
- Phase counter, 2 bits: phase <= p_tick ? 1 : phase+1. Phase 1 is the first cycle with the new x/y. Reset sets phase=0.
- Display slot: phase==1 && video_on.
  - Drive mem_addr = (y>>SCALE_SHIFT)*FB_W + (x>>SCALE_SHIFT), mem_we=0, gnt=00.
  - Set rd_pend.
  - The multiply is by a constant; result truncated to ADDR_W.
- Capture at the end of the phase==2 cycle:
  - vga_rgb <= rd_pend ? mem_rdata : 0.
  - vga_hsync <= hsync_in; vga_vsync <= vsync_in.
  - Clear rd_pend.
  - Net effect: outputs lag the counters by a fixed 2 clk and change together once per pixel.
- Writer slot: any cycle that is not a display slot, when reset=0, and (BLANK_ONLY=0 or video_on=0).
  - Both req bits set: grant writer ptr, then ptr <= ~granted index.
  - One req bit set: grant it, then ptr <= other index.
  - Granted cycle: mem_addr = that writer's address; mem_wdata = its data; mem_we=1 if address < FB_W*FB_H, else mem_we=0 and wr_err pulses next cycle.
  - No request: mem_we=0, mem_addr=0, ptr unchanged.
- Max writer wait with BLANK_ONLY=0: both requesting -> granted within 3 writer slots (<=5 clk).
- Reset, including mid-frame:
  - phase=0, ptr=0, rd_pend=0, vga_rgb=0, vga_hsync=0, vga_vsync=0, wr_err=0, gnt=00, mem_we=0.
  - Pending requests simply wait.
  - Resume aligns on the first p_tick after reset.
- A request deasserted before grant is dropped with no write. gnt never asserts for a low req bit.

Test Plan:
- x=4,y=8 at phase 1, video_on=1 -> mem_addr=2*160+1=321, mem_we=0; mem_rdata=0xABC in phase 2 -> vga_rgb=0xABC from the next cycle for 4 clk.
- req=11 continuously, ptr=0, video_on=1 -> gnt sequence 01,10,01 across phases 2,3,0; gnt=00 at phase 1; 0 writes lost.
- BLANK_ONLY=1, req=01 during video_on=1 -> gnt=00; first cycle with video_on=0 -> gnt=01, mem_we=1.
- req=10, wr_addr[1]=19200 -> gnt=10, mem_we=0, wr_err=1 next cycle only.
- hsync_in toggles at a p_tick -> vga_hsync toggles on the same edge as the corresponding vga_rgb update.
- Assert reset during phase 2 with rd_pend set -> all outputs 0 next cycle; after release, the first display read occurs at the phase 1 following the next p_tick.
